// File: rtl/rr_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_stream_arbiter_pkg
// Description : Shared types and helpers for the round-robin stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_stream_arbiter_pkg;

    // Arbiter state: free scan or locked onto one requester
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Increment an index and wrap to 0 after n-1; an explicit compare keeps
    // non-power-of-two requester counts correct.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_stream_arbiter_onehot_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_bin
// Description : One-hot (or all-zero) to binary index encoder. An all-zero
//               input encodes to 0. No priority resolution is done here; the
//               input is expected to carry at most one set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_bin #(
    parameter int ONEHOT_WIDTH = 4,
    parameter int BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] i_onehot,
    output logic [BIN_WIDTH-1:0]    o_bin
);

    logic [BIN_WIDTH-1:0] w_bin;

    // OR together the index of every set bit
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (i_onehot[i]) begin
                w_bin = w_bin | BIN_WIDTH'(i);
            end
        end
    end

    assign o_bin = w_bin;

endmodule
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_stream_arbiter
// Description : Round-robin arbiter sharing one valid/ready output stream
//               between NUM_IN requesters. Grant is combinational from the
//               request valids and is held stable while the output stalls.
//               Build option RR_ARB_BURST_EN: keep the grant on a requester
//               from its first beat until a beat with req_last_i set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = (NUM_IN == 1) ? 1 : $clog2(NUM_IN)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NUM_IN-1:0]        req_valid_i,
    output logic [NUM_IN-1:0]        req_ready_o,
    input  logic [NUM_IN*DATA_W-1:0] req_data_i,
    input  logic [NUM_IN-1:0]        req_last_i,
    output logic                     gnt_valid_o,
    input  logic                     gnt_ready_i,
    output logic [DATA_W-1:0]        gnt_data_o,
    output logic [IDX_W-1:0]         gnt_idx_o,
    output logic [NUM_IN-1:0]        gnt_onehot_o
);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [IDX_W-1:0]   w_lock_nxt;

    logic [NUM_IN-1:0]  w_scan_oh;
    logic               w_scan_hit;
    logic [NUM_IN-1:0]  w_lock_oh;
    logic [NUM_IN-1:0]  w_gnt_oh;
    logic [IDX_W-1:0]   w_win_idx;
    logic [DATA_W-1:0]  w_data;
    logic               w_gnt_valid;
    logic               w_fire;

`ifdef RR_ARB_BURST_EN
    logic               w_last;
    assign w_last = |(w_gnt_oh & req_last_i);
`else
    // End-of-burst markers carry no meaning when every beat is a transaction
    logic               w_unused_last;
    assign w_unused_last = ^req_last_i;
`endif

    // Rotating priority scan: first valid at or above the pointer, else first valid from 0
    always_comb begin
        w_scan_oh  = '0;
        w_scan_hit = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!w_scan_hit && req_valid_i[i] && (IDX_W'(i) >= r_ptr)) begin
                w_scan_oh[i] = 1'b1;
                w_scan_hit   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!w_scan_hit && req_valid_i[i]) begin
                w_scan_oh[i] = 1'b1;
                w_scan_hit   = 1'b1;
            end
        end
    end

    // Decode the locked index to one-hot without a variable bit-select
    always_comb begin
        w_lock_oh = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_lock_oh[i] = (IDX_W'(i) == r_lock_idx);
        end
    end

    // Output decode: pick the winner by state; everything is forced low during reset
    always_comb begin
        if (r_state == LOCKED) begin
            w_gnt_oh = w_lock_oh & req_valid_i;
        end else begin
            w_gnt_oh = w_scan_oh;
        end
        if (rst_i) begin
            w_gnt_oh = '0;
        end
    end

    // Payload mux: OR of the granted requester's data, zero when nothing is granted
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt_oh[i]) begin
                w_data = w_data | req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    onehot_to_bin #(
        .ONEHOT_WIDTH (NUM_IN),
        .BIN_WIDTH    (IDX_W)
    ) u_onehot_to_bin (
        .i_onehot (w_gnt_oh),
        .o_bin    (w_win_idx)
    );

    assign w_gnt_valid  = |w_gnt_oh;
    assign w_fire       = w_gnt_valid & gnt_ready_i;

    assign gnt_valid_o  = w_gnt_valid;
    assign gnt_onehot_o = w_gnt_oh;
    assign gnt_idx_o    = w_win_idx;
    assign gnt_data_o   = w_data;
    assign req_ready_o  = w_gnt_oh & {NUM_IN{gnt_ready_i}};

    // Next-state: pointer advance on completed transactions, lock on stalls
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock_idx;
        if (flush_i) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = '0;
            w_lock_nxt  = '0;
        end else begin
`ifdef RR_ARB_BURST_EN
            if (w_fire) begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = IDX_W'(next_idx(32'(w_win_idx), NUM_IN));
                end else begin
                    w_state_nxt = LOCKED;
                    w_lock_nxt  = w_win_idx;
                end
            end else if (w_gnt_valid) begin
                w_state_nxt = LOCKED;
                w_lock_nxt  = w_win_idx;
            end
            // A bubble while locked leaves state, lock and pointer untouched
`else
            if (w_fire) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = IDX_W'(next_idx(32'(w_win_idx), NUM_IN));
            end else if (w_gnt_valid) begin
                w_state_nxt = LOCKED;
                w_lock_nxt  = w_win_idx;
            end else if (r_state == LOCKED) begin
                // Locked requester withdrew its valid: fall back to scanning
                w_state_nxt = IDLE;
            end
`endif
        end
    end

    // State, pointer and lock registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_idx <= w_lock_nxt;
        end
    end

`ifndef SYNTHESIS
    a_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_onehot_o));

    a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (gnt_valid_o && !gnt_ready_i && !flush_i) |=>
        (!gnt_valid_o || ($stable(gnt_data_o) && $stable(gnt_idx_o))));

`ifndef RR_ARB_BURST_EN
    a_lock_valid_held : assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == LOCKED) |-> gnt_valid_o);
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_stream_arbiter
// Description : Directed self-checking bench for rr_stream_arbiter
//               (NUM_IN=4 main instance plus a NUM_IN=1 pass-through).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_stream_arbiter;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 32;

    logic                     r_clk = 1'b0;
    logic                     r_rst = 1'b1;
    logic                     r_flush = 1'b0;
    logic [NUM_IN-1:0]        r_req_valid = '0;
    logic [NUM_IN-1:0]        r_req_last = '0;
    logic [NUM_IN*DATA_W-1:0] r_req_data = '0;
    logic                     r_gnt_ready = 1'b0;

    logic [NUM_IN-1:0]        w_req_ready;
    logic                     w_gnt_valid;
    logic [DATA_W-1:0]        w_gnt_data;
    logic [1:0]               w_gnt_idx;
    logic [NUM_IN-1:0]        w_gnt_onehot;

    // Single-requester instance
    logic                     r1_valid = 1'b0;
    logic                     r1_ready = 1'b0;
    logic [7:0]               r1_data = 8'h00;
    logic [0:0]               w1_req_ready;
    logic                     w1_gnt_valid;
    logic [7:0]               w1_gnt_data;
    logic [0:0]               w1_gnt_idx;
    logic [0:0]               w1_gnt_onehot;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 r_clk = ~r_clk;

    rr_stream_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) u_dut (
        .clk_i        (r_clk),
        .rst_i        (r_rst),
        .flush_i      (r_flush),
        .req_valid_i  (r_req_valid),
        .req_ready_o  (w_req_ready),
        .req_data_i   (r_req_data),
        .req_last_i   (r_req_last),
        .gnt_valid_o  (w_gnt_valid),
        .gnt_ready_i  (r_gnt_ready),
        .gnt_data_o   (w_gnt_data),
        .gnt_idx_o    (w_gnt_idx),
        .gnt_onehot_o (w_gnt_onehot)
    );

    rr_stream_arbiter #(.NUM_IN(1), .DATA_W(8)) u_dut1 (
        .clk_i        (r_clk),
        .rst_i        (r_rst),
        .flush_i      (1'b0),
        .req_valid_i  (r1_valid),
        .req_ready_o  (w1_req_ready),
        .req_data_i   (r1_data),
        .req_last_i   (1'b1),
        .gnt_valid_o  (w1_gnt_valid),
        .gnt_ready_i  (r1_ready),
        .gnt_data_o   (w1_gnt_data),
        .gnt_idx_o    (w1_gnt_idx),
        .gnt_onehot_o (w1_gnt_onehot)
    );

    function automatic logic [31:0] payload(input int i);
        return 32'hC0DE_0000 + 32'(i * 32'h1111);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Full grant-side expectation for the 4-input instance
    task automatic expect_grant(input string tag, input logic v, input int idx);
        logic [3:0]  e_oh;
        logic [31:0] e_data;
        e_oh   = v ? (4'b0001 << idx) : 4'b0000;
        e_data = v ? payload(idx) : 32'h0;
        check_eq({tag, ".valid"},  64'(w_gnt_valid),  64'(v));
        check_eq({tag, ".idx"},    64'(w_gnt_idx),    v ? 64'(idx) : 64'(0));
        check_eq({tag, ".onehot"}, 64'(w_gnt_onehot), 64'(e_oh));
        check_eq({tag, ".data"},   64'(w_gnt_data),   64'(e_data));
        check_eq({tag, ".ready"},  64'(w_req_ready),  64'(e_oh & {4{r_gnt_ready}}));
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_IN; i++) begin
            r_req_data[i*DATA_W +: DATA_W] = payload(i);
        end

        // Reset with requests present: all outputs must stay quiet
        r_req_valid = 4'b1111;
        r_gnt_ready = 1'b1;
        r1_valid    = 1'b1;
        #2;
        expect_grant("reset", 1'b0, 0);
        check_eq("reset.n1_valid", 64'(w1_gnt_valid), 64'(0));
        tick();
        r_rst       = 1'b0;
        r_req_valid = 4'b0000;
        r1_valid    = 1'b0;
        #1;
        expect_grant("idle", 1'b0, 0);

        // 1: all valid, always ready -> 0,1,2,3,0,1,2,3
        r_req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            expect_grant($sformatf("rr%0d", k), 1'b1, k % 4);
            tick();
        end

        // 2: only req 2 with ptr 0, then all valid -> ptr moved to 3
        r_req_valid = 4'b0100;
        #1; expect_grant("only2", 1'b1, 2); tick();
        r_req_valid = 4'b1111;
        #1; expect_grant("after2", 1'b1, 3); tick();

        // 3: stall on req 1 for three cycles while req 0 arrives
        r_req_valid = 4'b0010;
        r_gnt_ready = 1'b0;
        #1; expect_grant("stall0", 1'b1, 1); tick();
        r_req_valid = 4'b0011;
        #1; expect_grant("stall1", 1'b1, 1); tick();
        #1; expect_grant("stall2", 1'b1, 1); tick();
        r_gnt_ready = 1'b1;
        #1; expect_grant("release", 1'b1, 1); tick();
        r_req_valid = 4'b0101;
        #1; expect_grant("post_rel2", 1'b1, 2); tick();
        r_req_valid = 4'b0011;
        #1; expect_grant("post_rel0", 1'b1, 0); tick();

        // 4: lock on req 2 (ptr 1), then asynchronous reset between edges
        r_req_valid = 4'b0100;
        r_gnt_ready = 1'b0;
        #1; expect_grant("lock_a", 1'b1, 2); tick();
        r_req_valid = 4'b0110;
        #1; expect_grant("lock_b", 1'b1, 2);
        #1; r_rst = 1'b1;
        #1; expect_grant("async_rst", 1'b0, 0);
        tick();
        r_rst       = 1'b0;
        r_req_valid = 4'b1111;
        r_gnt_ready = 1'b1;
        #1; expect_grant("after_rst", 1'b1, 0); tick();

        // 5: ptr to 3, then flush together with a fire of req 0
        r_req_valid = 4'b0100;
        #1; expect_grant("to_ptr3", 1'b1, 2); tick();
        r_req_valid = 4'b0001;
        r_flush     = 1'b1;
        #1; expect_grant("flush_fire", 1'b1, 0); tick();
        r_flush     = 1'b0;
        r_req_valid = 4'b1111;
        #1; expect_grant("post_flush", 1'b1, 0); tick();

        // Back to ptr 0 for the last-marker sequence
        r_req_valid = 4'b0000;
        r_flush     = 1'b1;
        tick();
        r_flush     = 1'b0;
        r_req_valid = 4'b0011;
        r_req_last  = 4'b0000;
`ifdef RR_ARB_BURST_EN
        // 6: req 0 burst of three with a bubble, req 1 waiting throughout
        #1; expect_grant("burst0", 1'b1, 0); tick();
        r_req_valid = 4'b0010;
        #1; expect_grant("bubble", 1'b0, 0); tick();
        r_req_valid = 4'b0011;
        #1; expect_grant("burst1", 1'b1, 0); tick();
        r_req_last  = 4'b0001;
        #1; expect_grant("burst2", 1'b1, 0); tick();
        r_req_last  = 4'b0000;
        #1; expect_grant("burst_next", 1'b1, 1); tick();
`else
        // Last markers are ignored: every beat rotates
        r_req_last  = 4'b0011;
        #1; expect_grant("nolast0", 1'b1, 0); tick();
        #1; expect_grant("nolast1", 1'b1, 1); tick();
        #1; expect_grant("nolast2", 1'b1, 0); tick();
        #1; expect_grant("nolast3", 1'b1, 1); tick();
`endif
        r_req_valid = 4'b0000;
        r_req_last  = 4'b0000;

        // Single-requester pass-through with hold
        r1_valid = 1'b1;
        r1_data  = 8'h5A;
        r1_ready = 1'b0;
        #1;
        check_eq("n1.valid", 64'(w1_gnt_valid), 64'(1));
        check_eq("n1.idx",   64'(w1_gnt_idx),   64'(0));
        check_eq("n1.data",  64'(w1_gnt_data),  64'(8'h5A));
        check_eq("n1.ready_stall", 64'(w1_req_ready), 64'(0));
        tick();
        r1_ready = 1'b1;
        #1;
        check_eq("n1.hold_data", 64'(w1_gnt_data),   64'(8'h5A));
        check_eq("n1.ready",     64'(w1_req_ready),  64'(1));
        check_eq("n1.onehot",    64'(w1_gnt_onehot), 64'(1));
        tick();
        r1_valid = 1'b0;
        #1;
        check_eq("n1.idle", 64'(w1_gnt_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
